// File: rtl/mips_pkg.sv
// Shared types and SRAM geometry for the MEM-stage external SRAM controller.
package mips_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage 32-bit access over a 16-bit SRAM as two half-word slots (LO, HI); ready in cycle 3, or 5 with SRAM_WAIT_STATE_EN.
// Backpressure: ready stays low from request to DONE so the pipeline freezes; requests are latched, not re-sampled.
module mem_stage_sram_ctrl
    import mips_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 MEM_R_EN,
    input  logic                 MEM_W_EN,
    input  logic [31:0]          ALU_result,
    input  logic [31:0]          ST_val,
    output logic                 ready,
    output logic [31:0]          Mem_read_value,
    output logic [SRAM_AW-1:0]   SRAM_ADDR,
    inout  wire  [SRAM_DW-1:0]   SRAM_DQ,
    output logic                 SRAM_WE_N,
    output logic                 SRAM_OE_N,
    output logic                 SRAM_CE_N,
    output logic                 SRAM_UB_N,
    output logic                 SRAM_LB_N
);

    mem_state_t           state, state_nxt;
    logic                 req;
    logic                 busy;
    logic                 slot_last;
    logic                 is_wr_q;
    logic [SRAM_AW-2:0]   addr_q;
    logic [31:0]          st_q;
    logic [SRAM_DW-1:0]   rd_lo_q;
    logic [SRAM_DW-1:0]   dq_out;
    logic                 dq_oe;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^{ALU_result[31:19], ALU_result[1:0]};

    assign req  = MEM_R_EN | MEM_W_EN;
    assign busy = (state == LO) || (state == HI);

`ifdef SRAM_WAIT_STATE_EN
    // First cycle of each slot is setup; the second strobes WE_N or captures DQ.
    logic wait_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q <= 1'b0;
        end else if (busy) begin
            wait_q <= ~wait_q;
        end else begin
            wait_q <= 1'b0;
        end
    end

    assign slot_last = wait_q;
`else
    assign slot_last = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = LO;
            LO:      if (slot_last) state_nxt = HI;
            HI:      if (slot_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Write wins when both enables are set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            st_q    <= '0;
        end else if (state == IDLE && req) begin
            is_wr_q <= MEM_W_EN;
            addr_q  <= ALU_result[18:2];
            st_q    <= ST_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_lo_q        <= '0;
            Mem_read_value <= '0;
        end else if (!is_wr_q && slot_last) begin
            if (state == LO) begin
                rd_lo_q <= SRAM_DQ;
            end else if (state == HI) begin
                Mem_read_value <= {SRAM_DQ, rd_lo_q};
            end
        end
    end

    assign ready = ((state == IDLE) && !req) || (state == DONE);

    always_comb begin
        SRAM_ADDR = {addr_q, (state == HI)};
        SRAM_CE_N = 1'b1;
        SRAM_UB_N = 1'b1;
        SRAM_LB_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = (state == HI) ? st_q[31:16] : st_q[15:0];
        if (busy) begin
            SRAM_CE_N = 1'b0;
            SRAM_UB_N = 1'b0;
            SRAM_LB_N = 1'b0;
            if (is_wr_q) begin
                dq_oe     = 1'b1;
                SRAM_WE_N = ~slot_last;
            end else begin
                SRAM_OE_N = 1'b0;
            end
        end
    end

    assign SRAM_DQ = dq_oe ? dq_out : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Scoreboard bench for mem_stage_sram_ctrl against a behavioural 16-bit SRAM.
// Per-cycle SRAM bus expectations and load results are queued at issue and retired as the DUT produces them.
module tb_mem_stage_sram_ctrl;

`ifdef SRAM_WAIT_STATE_EN
    localparam int SLOT = 2;
`else
    localparam int SLOT = 1;
`endif
    localparam int LAT = 2 * SLOT + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN, MEM_W_EN;
    logic [31:0] ALU_result, ST_val;
    logic        ready;
    logic [31:0] Mem_read_value;
    logic [17:0] SRAM_ADDR;
    wire  [15:0] SRAM_DQ;
    logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

    int n_chk  = 0;
    int n_pass = 0;

    logic [63:0] exp_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] ref_mem[int];
    logic [31:0] exp_rdval;

    logic [15:0] sram[0:1023];

    always #5 clk = ~clk;

    mem_stage_sram_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .MEM_R_EN       (MEM_R_EN),
        .MEM_W_EN       (MEM_W_EN),
        .ALU_result     (ALU_result),
        .ST_val         (ST_val),
        .ready          (ready),
        .Mem_read_value (Mem_read_value),
        .SRAM_ADDR      (SRAM_ADDR),
        .SRAM_DQ        (SRAM_DQ),
        .SRAM_WE_N      (SRAM_WE_N),
        .SRAM_OE_N      (SRAM_OE_N),
        .SRAM_CE_N      (SRAM_CE_N),
        .SRAM_UB_N      (SRAM_UB_N),
        .SRAM_LB_N      (SRAM_LB_N)
    );

    // Behavioural asynchronous SRAM, word index folded to 10 bits.
    assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? sram[SRAM_ADDR[9:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N) sram[SRAM_ADDR[9:0]] <= SRAM_DQ;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] bus_word(input logic ub, input logic lb, input logic we,
                                             input logic oe, input logic [17:0] a, input logic [15:0] d);
        return {26'd0, ub, lb, we, oe, a, d};
    endfunction

    // Every cycle the SRAM is selected must match the next queued expectation.
    always @(negedge clk) begin
        if (rst && !SRAM_CE_N) begin
            if (exp_q.size() == 0) check("unexpected_sram_cycle", 64'd1, 64'd0);
            else check("sram_cycle",
                       bus_word(SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_OE_N, SRAM_ADDR, SRAM_DQ),
                       exp_q.pop_front());
        end
    end

    task automatic push_exp(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] word;
        word = ref_mem.exists(int'(addr[18:2])) ? ref_mem[int'(addr[18:2])] : 32'h0;
        for (int h = 0; h < 2; h++) begin
            for (int i = 0; i < SLOT; i++) begin
                if (wr)
                    exp_q.push_back(bus_word(1'b0, 1'b0, (i == SLOT - 1) ? 1'b0 : 1'b1, 1'b1,
                                             {addr[18:2], h[0]}, h[0] ? data[31:16] : data[15:0]));
                else
                    exp_q.push_back(bus_word(1'b0, 1'b0, 1'b1, 1'b0,
                                             {addr[18:2], h[0]}, h[0] ? word[31:16] : word[15:0]));
            end
        end
        if (wr) ref_mem[int'(addr[18:2])] = data;
        else rd_q.push_back(word);
    endtask

    task automatic drop_inputs();
        MEM_R_EN   = 1'b0;
        MEM_W_EN   = 1'b0;
        ALU_result = 32'h0000_0FFC;
        ST_val     = 32'h0;
    endtask

    // drop_cycle > 0 removes/changes the request mid-access; reps > 1 holds it through DONE.
    task automatic run_access(input logic wr_en, input logic rd_en, input logic [31:0] addr,
                              input logic [31:0] data, input int drop_cycle, input int reps);
        int n;
        bit done;
        for (int r = 0; r < reps; r++) push_exp(wr_en, addr, data);
        @(posedge clk); #1;
        MEM_W_EN = wr_en; MEM_R_EN = rd_en; ALU_result = addr; ST_val = data;
        @(negedge clk);
        check("ready_low_on_req", ready, 0);
        for (int r = 0; r < reps; r++) begin
            n = 0; done = 0;
            while (!done && n < 50) begin
                @(negedge clk);
                n++;
                if (ready) done = 1;
                if (n == drop_cycle) drop_inputs();
            end
            check("latency", n, LAT);
            if (!wr_en) exp_rdval = rd_q.pop_front();
            check(wr_en ? "rdval_unchanged_by_write" : "rdval", Mem_read_value, exp_rdval);
            if (r < reps - 1) begin
                @(negedge clk);
                check("b2b_ready_low_in_idle", ready, 0);
            end
        end
        drop_inputs();
        @(negedge clk);
        check("ready_idle", ready, 1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) sram[i] = 16'h0;
        rst = 1'b0;
        exp_rdval = 32'h0;
        drop_inputs();

        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_rdval", Mem_read_value, 32'h0);
        check("rst_strobes", {SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 5'b11111);
        check("rst_dq_z", SRAM_DQ === 16'hzzzz, 1);
        rst = 1'b1;
        @(negedge clk);
        check("idle_ready", ready, 1);

        run_access(1'b1, 1'b0, 32'h0000_0408, 32'hDEAD_BEEF, 0, 1);
        run_access(1'b0, 1'b1, 32'h0000_0408, 32'h0, 0, 1);
        repeat (3) @(negedge clk);
        check("rdval_held", Mem_read_value, 32'hDEAD_BEEF);

        // Both enables set: must write.
        run_access(1'b1, 1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 0, 1);
        // Request dropped and address changed in cycle 1; low address bits ignored.
        run_access(1'b0, 1'b1, 32'h0000_0013, 32'h0, 1, 1);
        // Address bits above 18 ignored; top of the 18-bit space.
        run_access(1'b1, 1'b0, 32'hFFF7_FFFC, 32'h0123_4567, 0, 1);
        run_access(1'b0, 1'b1, 32'h0007_FFFC, 32'h0, 0, 1);
        // Back-to-back writes held through DONE.
        run_access(1'b1, 1'b0, 32'h0000_0020, 32'h1357_9BDF, 0, 2);

        // Reset asserted during the HI slot of a write.
        @(posedge clk); #1;
        MEM_W_EN = 1'b1; ALU_result = 32'h0000_0800; ST_val = 32'h1234_5678;
        push_exp(1'b1, 32'h0000_0800, 32'h1234_5678);
        ref_mem.delete(int'(32'h200));
        repeat (SLOT + 1) @(posedge clk);
        #1;
        check("pre_rst_in_hi", {SRAM_CE_N, SRAM_ADDR[0]}, 2'b01);
        rst = 1'b0;
        drop_inputs();
        #1;
        check("midrst_strobes", {SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 5'b11111);
        check("midrst_dq_z", SRAM_DQ === 16'hzzzz, 1);
        check("midrst_ready", ready, 1);
        check("midrst_rdval", Mem_read_value, 32'h0);
        exp_q.delete();
        exp_rdval = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        run_access(1'b0, 1'b1, 32'h0000_0408, 32'h0, 0, 1);

        if (exp_q.size() != 0) check("sram_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
